// File: rtl/ex_muldiv_sequencer_if.sv
// rtl/ex_muldiv_sequencer_if.sv - EX-stage request/result bundle for the mul/div sequencer
interface ex_muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             ex_valid;
    logic             is_mul;
    logic             is_div;
    logic             is_mod;
    logic             flush;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             stall_ex;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] result;

    modport master (
        output ex_valid, is_mul, is_div, is_mod, flush, operand_a, operand_b,
        input  stall_ex, busy, result_valid, result
    );

    modport slave (
        input  ex_valid, is_mul, is_div, is_mod, flush, operand_a, operand_b,
        output stall_ex, busy, result_valid, result
    );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// rtl/ex_muldiv_sequencer.sv - iterative shift-add multiply / restoring divide for the EX stage
module ex_muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ex_muldiv_sequencer_if.slave  ex
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             op_mul, op_div;
    // acc: product accumulator or partial remainder
    // opb: shifting multiplicand or divisor; opc: multiplier or dividend/quotient
    logic [WIDTH-1:0] acc, opb, opc;

    logic             start_req, sel_mul, sel_div, div_by_zero, last_iter;
    logic [WIDTH-1:0] mul_acc_nxt, rem_nxt, quo_nxt;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;

    assign start_req   = ex.ex_valid & (ex.is_mul | ex.is_div | ex.is_mod) & ~ex.flush;
    assign sel_mul     = ex.is_mul;
    assign sel_div     = ~ex.is_mul & ex.is_div;
    assign div_by_zero = ~sel_mul & (ex.operand_b == '0);
    assign last_iter   = (cnt == CNT_W'(1));

    assign mul_acc_nxt = opc[0] ? acc + opb : acc;
    assign rem_shift   = {acc, opc[WIDTH-1]};
    assign rem_ge      = rem_shift >= {1'b0, opb};
    assign rem_nxt     = rem_ge ? WIDTH'(rem_shift - {1'b0, opb}) : rem_shift[WIDTH-1:0];
    assign quo_nxt     = {opc[WIDTH-2:0], rem_ge};

    assign ex.stall_ex = (((state == IDLE) & start_req) | (state == RUN)) & ~ex.flush;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_req) state_nxt = div_by_zero ? DONE : RUN;
            RUN: begin
                if (ex.flush)      state_nxt = IDLE;
                else if (last_iter) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            op_mul          <= 1'b0;
            op_div          <= 1'b0;
            acc             <= '0;
            opb             <= '0;
            opc             <= '0;
            ex.busy         <= 1'b0;
            ex.result_valid <= 1'b0;
            ex.result       <= '0;
        end else begin
            ex.result_valid <= 1'b0;
            ex.busy         <= (state_nxt == RUN);
            case (state)
                IDLE: begin
                    if (start_req) begin
                        op_mul <= sel_mul;
                        op_div <= sel_div;
                        acc    <= '0;
                        opb    <= sel_mul ? ex.operand_a : ex.operand_b;
                        opc    <= sel_mul ? ex.operand_b : ex.operand_a;
                        if (div_by_zero) begin
                            cnt             <= '0;
                            ex.result       <= sel_div ? '1 : ex.operand_a;
                            ex.result_valid <= 1'b1;
                        end else begin
                            cnt <= CNT_W'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    if (ex.flush) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (op_mul) begin
                            acc <= mul_acc_nxt;
                            opb <= opb << 1;
                            opc <= opc >> 1;
                        end else begin
                            acc <= rem_nxt;
                            opc <= quo_nxt;
                        end
                        if (last_iter) begin
                            ex.result_valid <= 1'b1;
                            ex.result       <= op_mul ? mul_acc_nxt : (op_div ? quo_nxt : rem_nxt);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb/tb_ex_muldiv_sequencer.sv - scoreboard bench for ex_muldiv_sequencer
module tb_ex_muldiv_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_sequencer_if #(.WIDTH(W)) bus ();

    ex_muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_result = '0;

    function automatic logic [W-1:0] model(bit m, bit d, logic [W-1:0] a, logic [W-1:0] b);
        if (m) return a * b;
        if (d) return (b == 0) ? {W{1'b1}} : a / b;
        return (b == 0) ? a : a % b;
    endfunction

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result_valid", 32'd1, 32'd0);
            end else begin
                check("result", bus.result, exp_q.pop_front());
            end
        end
    end

    task automatic idle_inputs();
        bus.ex_valid  = 1'b0;
        bus.is_mul    = 1'b0;
        bus.is_div    = 1'b0;
        bus.is_mod    = 1'b0;
        bus.flush     = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
    endtask

    // Called at posedge+1; holds the instruction in EX until stall_ex releases it.
    task automatic issue(bit m, bit d, bit md, logic [W-1:0] a, logic [W-1:0] b, bit scramble);
        bit eff_m, eff_d, zero_div, st, busy_bad;
        int cyc, stalls, exp_stalls;
        eff_m      = m;
        eff_d      = !m && d;
        zero_div   = !eff_m && (b == 0);
        exp_stalls = zero_div ? 1 : W + 1;
        last_result = model(eff_m, eff_d, a, b);
        exp_q.push_back(last_result);
        bus.ex_valid  = 1'b1;
        bus.is_mul    = m;
        bus.is_div    = d;
        bus.is_mod    = md;
        bus.operand_a = a;
        bus.operand_b = b;
        cyc = 0; stalls = 0; busy_bad = 0;
        forever begin
            @(negedge clk);
            st = bus.stall_ex;
            if (bus.busy !== ((cyc > 0) && st)) busy_bad = 1;
            if (st) stalls++;
            @(posedge clk); #1;
            if (scramble) begin
                bus.operand_a = $urandom;
                bus.operand_b = $urandom;
            end
            if (!st) break;
            cyc++;
            if (cyc > 3 * W) begin
                check("stall_timeout", 32'(cyc), 32'(exp_stalls));
                break;
            end
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        check("busy_profile", 32'(busy_bad), 32'd0);
        idle_inputs();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit m, d, md;
        logic [W-1:0] a, b, prev;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_valid", 32'(bus.result_valid), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_stall", 32'(bus.stall_ex), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(1, 0, 0, 32'd7, 32'd6, 0);
        issue(0, 1, 0, 32'd100, 32'd7, 0);
        issue(0, 0, 1, 32'd100, 32'd7, 0);
        issue(0, 1, 0, 32'd5, 32'd0, 0);
        issue(0, 0, 1, 32'd5, 32'd0, 0);
        issue(1, 0, 0, 32'hFFFF_FFFF, 32'd2, 0);
        issue(1, 1, 0, 32'd3, 32'd4, 0);
        issue(0, 1, 1, 32'd9, 32'd4, 0);
        drain();

        // Flush mid-RUN: no result, previous result held
        prev = last_result;
        bus.ex_valid = 1'b1; bus.is_div = 1'b1;
        bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        #1;
        check("flush_stall_drop", 32'(bus.stall_ex), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        check("flush_busy", 32'(bus.busy), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_result_held", bus.result, prev);
        check("flush_stall_idle", 32'(bus.stall_ex), 32'd0);

        // Asynchronous reset mid-MUL
        bus.ex_valid = 1'b1; bus.is_mul = 1'b1;
        bus.operand_a = 32'd12345; bus.operand_b = 32'd678;
        repeat (15) begin @(posedge clk); #1; end
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.result_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_stall", 32'(bus.stall_ex), 32'd0);
        last_result = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1, 0, 0, 32'd3, 32'd3, 0);

        for (int i = 0; i < 40; i++) begin
            m  = ($urandom_range(0, 2) == 0);
            d  = $urandom_range(0, 1);
            md = $urandom_range(0, 1);
            if (!m && !d && !md) md = 1'b1;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
            issue(m, d, md, a, b, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
